// File: rtl/axi_pe_master.sv
// axi_pe_master: AXI4 master engine on the PE side of the NoC network interface.
// Turns single-command requests from the PE sequencer into INCR bursts toward the NI
// AXI slave. One transaction is in flight at a time, and completion status is reported back.
//
// Ports:
//   clk_axi, arst_axi     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_write, cmd_addr, cmd_len (beats - 1)
//   wr_data/valid/ready   write payload stream, passed straight through to the W channel
//   rd_data/valid/last    read payload stream from the R channel; rd_ready is its ready
//   done, done_err        one-cycle completion pulse and its error flag
//   axi_mosi_if           packed master-to-slave bundle, MSB first:
//                         {awvalid, awaddr, awlen, awsize, awburst,
//                          wvalid, wdata, wstrb, wlast, bready,
//                          arvalid, araddr, arlen, arsize, arburst, rready}
//   axi_miso_if           packed slave-to-master bundle, MSB first:
//                         {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast}
module axi_pe_master #(
   parameter int unsigned ASIZE          = 2,
   parameter int unsigned MAX_LEN        = 255,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ALEN_WIDTH = 8,
   localparam int unsigned MOSI_WIDTH    = 2 * AXI_ADDR_WIDTH + 2 * AXI_ALEN_WIDTH
                                           + AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 16,
   localparam int unsigned MISO_WIDTH    = AXI_DATA_WIDTH + 10
) (
   input  logic                      clk_axi,
   input  logic                      arst_axi,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AXI_ALEN_WIDTH-1:0] cmd_len,
   input  logic [AXI_DATA_WIDTH-1:0] wr_data,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   output logic [AXI_DATA_WIDTH-1:0] rd_data,
   output logic                      rd_valid,
   output logic                      rd_last,
   input  logic                      rd_ready,
   output logic                      done,
   output logic                      done_err,
   output logic [MOSI_WIDTH-1:0]     axi_mosi_if,
   input  logic [MISO_WIDTH-1:0]     axi_miso_if
);

   localparam logic [2:0]                SizeCode = 3'(ASIZE);
   localparam logic [1:0]                BurstIncr = 2'b01;
   localparam logic [1:0]                RespOkay  = 2'b00;
   localparam logic [AXI_ALEN_WIDTH-1:0] MaxLen    = AXI_ALEN_WIDTH'(MAX_LEN);
   localparam logic [AXI_ALEN_WIDTH:0]   BeatOne   = 1;

   typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StDone} state_e;

   state_e                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXI_ALEN_WIDTH-1:0] len_q, len_d;
   // One bit wider than the length field so a 256-beat burst cannot wrap the counter.
   logic [AXI_ALEN_WIDTH:0]   beat_q, beat_d;
   logic                      err_q, err_d;
   logic [AXI_ALEN_WIDTH-1:0] len_sat;
   logic                      last_beat;

   // Unpacked AXI channel signals.
   logic                      awvalid, wvalid, wlast, bready, arvalid, rready;
   logic [AXI_ADDR_WIDTH-1:0] awaddr, araddr;
   logic [AXI_ALEN_WIDTH-1:0] awlen, arlen;
   logic [2:0]                awsize, arsize;
   logic [1:0]                awburst, arburst;
   logic [AXI_DATA_WIDTH-1:0] wdata;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                      awready, wready, bvalid, arready, rvalid, rlast;
   logic [1:0]                bresp, rresp;
   logic [AXI_DATA_WIDTH-1:0] rdata;

   assign axi_mosi_if = {awvalid, awaddr, awlen, awsize, awburst,
                         wvalid, wdata, wstrb, wlast, bready,
                         arvalid, araddr, arlen, arsize, arburst, rready};
   assign {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast} = axi_miso_if;

   // Oversized lengths saturate; the saturated value is what goes on the bus.
   assign len_sat   = (32'(cmd_len) > MAX_LEN) ? MaxLen : cmd_len;
   assign last_beat = (beat_q == {1'b0, len_q});

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      beat_d    = beat_q;
      err_d     = err_q;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      rd_data   = '0;
      rd_valid  = 1'b0;
      rd_last   = 1'b0;
      done      = 1'b0;
      done_err  = 1'b0;
      awvalid   = 1'b0;
      awaddr    = '0;
      awlen     = '0;
      awsize    = '0;
      awburst   = '0;
      wvalid    = 1'b0;
      wdata     = '0;
      wstrb     = '0;
      wlast     = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      araddr    = '0;
      arlen     = '0;
      arsize    = '0;
      arburst   = '0;
      rready    = 1'b0;

      case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               len_d   = len_sat;
               beat_d  = '0;
               err_d   = 1'b0;
               state_d = cmd_write ? StAw : StAr;
            end
         end
         StAw: begin
            awvalid = 1'b1;
            awaddr  = addr_q;
            awlen   = len_q;
            awsize  = SizeCode;
            awburst = BurstIncr;
            if (awready) state_d = StW;
         end
         StW: begin
            wvalid   = wr_valid;
            wdata    = wr_data;
            wstrb    = '1;
            wlast    = last_beat;
            wr_ready = wready;
            if (wr_valid && wready) begin
               beat_d = beat_q + BeatOne;
               if (last_beat) state_d = StB;
            end
         end
         StB: begin
            bready = 1'b1;
            if (bvalid) begin
               if (bresp != RespOkay) err_d = 1'b1;
               state_d = StDone;
            end
         end
         StAr: begin
            arvalid = 1'b1;
            araddr  = addr_q;
            arlen   = len_q;
            arsize  = SizeCode;
            arburst = BurstIncr;
            if (arready) state_d = StR;
         end
         StR: begin
            rd_valid = rvalid;
            rd_data  = rdata;
            rd_last  = rlast;
            rready   = rd_ready;
            if (rvalid && rd_ready) begin
               beat_d = beat_q + BeatOne;
               if (rresp != RespOkay) err_d = 1'b1;
               if (rlast) begin
                  // rlast before the programmed length: slave cut the burst short.
                  if (!last_beat) err_d = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            done     = 1'b1;
            done_err = err_q;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_axi or posedge arst_axi) begin
      if (arst_axi) begin
         state_q <= StIdle;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_axi_pe_master.sv
// Directed self-checking bench for axi_pe_master. The AXI slave and the PE sequencer are
// modelled inline, one cycle at a time: inputs change on the falling edge and outputs are
// sampled 1 time unit later, well before the next rising edge.
module tb_axi_pe_master;

   logic         clk_axi = 1'b0;
   logic         arst_axi;
   logic         cmd_valid, cmd_ready, cmd_write;
   logic [31:0]  cmd_addr;
   logic [7:0]   cmd_len;
   logic [31:0]  wr_data;
   logic         wr_valid, wr_ready;
   logic [31:0]  rd_data;
   logic         rd_valid, rd_last, rd_ready;
   logic         done, done_err;
   logic [131:0] axi_mosi_if;
   logic [41:0]  axi_miso_if;

   logic         m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
   logic [31:0]  m_awaddr, m_araddr, m_wdata;
   logic [7:0]   m_awlen, m_arlen;
   logic [2:0]   m_awsize, m_arsize;
   logic [1:0]   m_awburst, m_arburst;
   logic [3:0]   m_wstrb;

   logic         s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
   logic [1:0]   s_bresp, s_rresp;
   logic [31:0]  s_rdata;

   int checks   = 0;
   int failures = 0;

   assign {m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
           m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
           m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready} = axi_mosi_if;
   assign axi_miso_if = {s_awready, s_wready, s_bvalid, s_bresp, s_arready,
                         s_rvalid, s_rdata, s_rresp, s_rlast};

   axi_pe_master #(
      .ASIZE   (2),
      .MAX_LEN (15)
   ) dut (
      .clk_axi     (clk_axi),
      .arst_axi    (arst_axi),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_last     (rd_last),
      .rd_ready    (rd_ready),
      .done        (done),
      .done_err    (done_err),
      .axi_mosi_if (axi_mosi_if),
      .axi_miso_if (axi_miso_if)
   );

   always #5 clk_axi = ~clk_axi;

   task automatic idle_inputs();
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0;
   endtask

   // Presents a command for one cycle; the accepting edge is the following rising edge.
   task automatic accept(input logic w, input logic [31:0] a, input logic [7:0] l);
      @(negedge clk_axi);
      idle_inputs();
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      @(posedge clk_axi);
   endtask

   task automatic test_reset();
      arst_axi = 1'b1;
      idle_inputs();
      s_rvalid = 1'b1; rd_ready = 1'b1; wr_valid = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready);
      end
      checks++;
      if (axi_mosi_if !== '0) begin
         failures++; $display("FAIL rst_mosi got=%0h exp=0", axi_mosi_if);
      end
      checks++;
      if ({wr_ready, rd_valid, rd_last, done, done_err, rd_data} !== '0) begin
         failures++;
         $display("FAIL rst_outs got=%0h exp=0", {wr_ready, rd_valid, rd_last, done, done_err, rd_data});
      end
      idle_inputs();
      @(negedge clk_axi);
      @(negedge clk_axi);
      arst_axi = 1'b0;
   endtask

   task automatic test_single_write();
      accept(1'b1, 32'h1000, 8'd0);
      @(negedge clk_axi);
      cmd_valid = 1'b0; s_awready = 1'b1; s_wready = 1'b1;
      wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
      #1;
      checks++;
      if ({m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst} !== {1'b1, 32'h1000, 8'd0, 3'd2, 2'b01})
      begin
         failures++;
         $display("FAIL sw_aw got=%0h exp=%0h", {m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst},
                  {1'b1, 32'h1000, 8'd0, 3'd2, 2'b01});
      end
      checks++;
      if ({wr_ready, m_wvalid} !== 2'b00) begin
         failures++; $display("FAIL sw_w_early got=%0b exp=00", {wr_ready, m_wvalid});
      end
      @(negedge clk_axi);
      #1;
      checks++;
      if ({m_wvalid, m_wdata, m_wstrb, m_wlast, wr_ready, m_awvalid} !==
          {1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sw_w got=%0h exp=%0h", {m_wvalid, m_wdata, m_wstrb, m_wlast, wr_ready, m_awvalid},
                  {1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0});
      end
      @(negedge clk_axi);
      wr_valid = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b00;
      #1;
      checks++;
      if ({m_bready, done} !== 2'b10) begin
         failures++; $display("FAIL sw_b got=%0b exp=10", {m_bready, done});
      end
      @(negedge clk_axi);
      s_bvalid = 1'b0;
      #1;
      checks++;
      if ({done, done_err} !== 2'b10) begin
         failures++; $display("FAIL sw_done got=%0b exp=10", {done, done_err});
      end
      @(negedge clk_axi);
      #1;
      checks++;
      if ({cmd_ready, done} !== 2'b10) begin
         failures++; $display("FAIL sw_idle got=%0b exp=10", {cmd_ready, done});
      end
   endtask

   // len 3, wready toggling; bvalid is held high from the start with SLVERR until the last W
   // handshake, so any early B acceptance shows up as an error or an early finish.
   task automatic test_burst_write();
      logic [31:0] data [4];
      int          n = 0;
      bit          fin = 1'b0;
      for (int i = 0; i < 4; i++) data[i] = 32'hA000_0000 + 32'(i);
      accept(1'b1, 32'h3000, 8'd3);
      for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
         @(negedge clk_axi);
         cmd_valid = 1'b0; s_awready = 1'b1; s_wready = cyc[0];
         wr_valid = (n < 4); wr_data = (n < 4) ? data[n] : '0;
         s_bvalid = 1'b1; s_bresp = (n < 4) ? 2'b10 : 2'b00;
         #1;
         if (cyc == 0) begin
            checks++;
            if ({m_awvalid, m_awaddr, m_awlen} !== {1'b1, 32'h3000, 8'd3}) begin
               failures++; $display("FAIL bw_aw got=%0h exp=%0h", {m_awvalid, m_awaddr, m_awlen},
                                    {1'b1, 32'h3000, 8'd3});
            end
         end
         checks++;
         if (n < 4 && m_bready) begin
            failures++; $display("FAIL bw_early_bready got=1 exp=0 beat=%0d", n);
         end
         if (m_wvalid && s_wready) begin
            checks++;
            if ({m_wdata, m_wlast, wr_ready} !== {data[n], (n == 3), 1'b1}) begin
               failures++;
               $display("FAIL bw_beat%0d got=%0h exp=%0h", n, {m_wdata, m_wlast, wr_ready},
                        {data[n], (n == 3), 1'b1});
            end
            n++;
         end
         if (done) begin
            checks++;
            if (done_err !== 1'b0) begin
               failures++; $display("FAIL bw_done_err got=%0b exp=0", done_err);
            end
            fin = 1'b1;
         end
      end
      checks++;
      if (!fin || n != 4) begin
         failures++; $display("FAIL bw_complete got=done%0b/beats%0d exp=done1/beats4", fin, n);
      end
   endtask

   task automatic test_burst_read();
      int j = 0;
      bit ar_done = 1'b0;
      bit fin = 1'b0;
      accept(1'b0, 32'h2000, 8'd7);
      for (int cyc = 0; cyc < 120 && !fin; cyc++) begin
         @(negedge clk_axi);
         cmd_valid = 1'b0; s_arready = 1'b1;
         s_rvalid = ar_done && (j < 8); s_rdata = 32'hB000_0000 + 32'(j);
         s_rlast = (j == 7); s_rresp = 2'b00;
         rd_ready = 1'($urandom_range(0, 1));
         #1;
         if (cyc == 0) begin
            checks++;
            if ({m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst} !==
                {1'b1, 32'h2000, 8'd7, 3'd2, 2'b01}) begin
               failures++;
               $display("FAIL br_ar got=%0h exp=%0h", {m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst},
                        {1'b1, 32'h2000, 8'd7, 3'd2, 2'b01});
            end
         end
         if (s_rvalid) begin
            checks++;
            if ({rd_valid, m_rready} !== {1'b1, rd_ready}) begin
               failures++; $display("FAIL br_fwd got=%0b exp=%0b", {rd_valid, m_rready}, {1'b1, rd_ready});
            end
         end
         if (rd_valid && rd_ready) begin
            checks++;
            if ({rd_data, rd_last} !== {32'hB000_0000 + 32'(j), (j == 7)}) begin
               failures++;
               $display("FAIL br_beat%0d got=%0h exp=%0h", j, {rd_data, rd_last},
                        {32'hB000_0000 + 32'(j), (j == 7)});
            end
            j++;
         end
         if (m_arvalid && s_arready) ar_done = 1'b1;
         if (done) begin
            checks++;
            if (done_err !== 1'b0) begin
               failures++; $display("FAIL br_done_err got=%0b exp=0", done_err);
            end
            fin = 1'b1;
         end
      end
      checks++;
      if (!fin || j != 8) begin
         failures++; $display("FAIL br_complete got=done%0b/beats%0d exp=done1/beats8", fin, j);
      end
   endtask

   // k=0: len 0, single SLVERR beat. k=1: len 3, OKAY beat but rlast on the first beat.
   task automatic test_read_error();
      for (int k = 0; k < 2; k++) begin
         accept(1'b0, 32'hDEAD_0000, (k == 0) ? 8'd0 : 8'd3);
         @(negedge clk_axi);
         cmd_valid = 1'b0; s_arready = 1'b1; rd_ready = 1'b1;
         #1;
         checks++;
         if (m_arvalid !== 1'b1) begin
            failures++; $display("FAIL re%0d_ar got=%0b exp=1", k, m_arvalid);
         end
         @(negedge clk_axi);
         s_rvalid = 1'b1; s_rlast = 1'b1; s_rresp = (k == 0) ? 2'b10 : 2'b00;
         #1;
         checks++;
         if ({rd_valid, rd_last, m_rready} !== 3'b111) begin
            failures++; $display("FAIL re%0d_r got=%0b exp=111", k, {rd_valid, rd_last, m_rready});
         end
         @(negedge clk_axi);
         s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'b00;
         #1;
         checks++;
         if ({done, done_err} !== 2'b11) begin
            failures++; $display("FAIL re%0d_done got=%0b exp=11", k, {done, done_err});
         end
         @(negedge clk_axi);
         #1;
         checks++;
         if ({cmd_ready, done, rd_valid} !== 3'b100) begin
            failures++; $display("FAIL re%0d_idle got=%0b exp=100", k, {cmd_ready, done, rd_valid});
         end
      end
   endtask

   task automatic test_write_error();
      accept(1'b1, 32'h4000, 8'd1);
      @(negedge clk_axi);
      cmd_valid = 1'b0; s_awready = 1'b1; s_wready = 1'b1; wr_valid = 1'b1; wr_data = 32'h11;
      #1;
      checks++;
      if ({m_awvalid, m_awlen} !== {1'b1, 8'd1}) begin
         failures++; $display("FAIL we_aw got=%0h exp=101", {m_awvalid, m_awlen});
      end
      @(negedge clk_axi);
      #1;
      checks++;
      if ({m_wvalid, m_wdata, m_wlast} !== {1'b1, 32'h11, 1'b0}) begin
         failures++; $display("FAIL we_w0 got=%0h exp=%0h", {m_wvalid, m_wdata, m_wlast}, {1'b1, 32'h11, 1'b0});
      end
      @(negedge clk_axi);
      wr_data = 32'h22;
      #1;
      checks++;
      if ({m_wvalid, m_wdata, m_wlast} !== {1'b1, 32'h22, 1'b1}) begin
         failures++; $display("FAIL we_w1 got=%0h exp=%0h", {m_wvalid, m_wdata, m_wlast}, {1'b1, 32'h22, 1'b1});
      end
      @(negedge clk_axi);
      wr_valid = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b10;
      #1;
      checks++;
      if (m_bready !== 1'b1) begin
         failures++; $display("FAIL we_b got=%0b exp=1", m_bready);
      end
      @(negedge clk_axi);
      s_bvalid = 1'b0; s_bresp = 2'b00;
      #1;
      checks++;
      if ({done, done_err} !== 2'b11) begin
         failures++; $display("FAIL we_done got=%0b exp=11", {done, done_err});
      end
      // The following command must be accepted and must not inherit the error.
      test_single_write();
   endtask

   task automatic test_len_clamp();
      accept(1'b0, 32'h5000, 8'd40);
      @(negedge clk_axi);
      cmd_valid = 1'b0; s_arready = 1'b1; rd_ready = 1'b1;
      #1;
      checks++;
      if ({m_arvalid, m_arlen} !== {1'b1, 8'd15}) begin
         failures++; $display("FAIL clamp_arlen got=%0h exp=10f", {m_arvalid, m_arlen});
      end
      @(negedge clk_axi);
      s_rvalid = 1'b1; s_rlast = 1'b1;
      @(negedge clk_axi);
      s_rvalid = 1'b0; s_rlast = 1'b0;
      #1;
      checks++;
      if ({done, done_err} !== 2'b11) begin
         failures++; $display("FAIL clamp_done got=%0b exp=11", {done, done_err});
      end
   endtask

   task automatic test_reset_mid_write();
      accept(1'b1, 32'h6000, 8'd5);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk_axi);
         cmd_valid = 1'b0; s_awready = 1'b1; s_wready = 1'b1; wr_valid = 1'b1;
         wr_data = 32'hC000_0000 + 32'(c);
      end
      #1;
      checks++;
      if ({m_wvalid, m_wlast} !== 2'b10) begin
         failures++; $display("FAIL rm_beat2 got=%0b exp=10", {m_wvalid, m_wlast});
      end
      arst_axi = 1'b1;
      #1;
      checks++;
      if (axi_mosi_if !== '0) begin
         failures++; $display("FAIL rm_mosi got=%0h exp=0", axi_mosi_if);
      end
      checks++;
      if ({cmd_ready, wr_ready, rd_valid, rd_last, done, done_err} !== 6'b100000) begin
         failures++;
         $display("FAIL rm_outs got=%0b exp=100000", {cmd_ready, wr_ready, rd_valid, rd_last, done, done_err});
      end
      @(negedge clk_axi);
      @(negedge clk_axi);
      arst_axi = 1'b0;
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if ({cmd_ready, done, m_awvalid, m_wvalid} !== 4'b1000) begin
            failures++;
            $display("FAIL rm_after%0d got=%0b exp=1000", c, {cmd_ready, done, m_awvalid, m_wvalid});
         end
         @(negedge clk_axi);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst_write();
      test_burst_read();
      test_read_error();
      test_write_error();
      test_len_clamp();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_pe_master.md
# axi_pe_master

AXI4 master engine on the processing-element side of a NoC network interface. It turns single-command requests from a PE-local sequencer into complete AXI bursts toward the NI AXI slave. Writes push packet flits into the NoC TX virtual-channel FIFOs; reads drain the RX virtual-channel buffers. It handles one transaction at a time, supports INCR bursts only, and reports completion status back to the sequencer.

## Interface
Parameters:
- ASIZE, 2: AXI beat size code for awsize and arsize (2 = 4 bytes).
- MAX_LEN, 255: largest legal cmd_len, in beats minus 1.

Ports:
- clk_axi  in  1  AXI clock.
- arst_axi  in  1  Asynchronous, active-high reset.
- cmd_valid  in  1  Command request.
- cmd_ready  out  1  Command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AXI_ADDR_WIDTH  Burst start address (VC FIFO or CSR address).
- cmd_len  in  AXI_ALEN_WIDTH  Beats minus 1.
- wr_data  in  AXI_DATA_WIDTH  Write payload stream.
- wr_valid  in  1  Write payload valid.
- wr_ready  out  1  Write payload accepted.
- rd_data  out  AXI_DATA_WIDTH  Read payload stream.
- rd_valid  out  1  Read payload valid.
- rd_last  out  1  Last read beat.
- rd_ready  in  1  Sequencer accepts read beat.
- done  out  1  One-cycle pulse when a transaction finishes.
- done_err  out  1  Valid with done; 1 = any non-OKAY response or early rlast.
- axi_mosi_if  out  s_axi_mosi_t  AXI master-to-slave signals.
- axi_miso_if  in  s_axi_miso_t  AXI slave-to-master signals.

## Operation
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- **IDLE**
  - cmd_ready = 1.
  - On command accept, register cmd_addr, cmd_len and cmd_write; clear beat_cnt and err.
  - Go to AW if cmd_write = 1, else AR.
- **AW**
  - Drive awvalid = 1, with awaddr and awlen from registers, awsize = ASIZE, awburst = INCR.
  - Hold all AW fields stable until awready; then go to W.
- **W**
  - Combinational pass-through: wvalid = wr_valid, wdata = wr_data, wready forwarded to wr_ready.
  - wstrb is all ones. wlast = (beat_cnt == len).
  - beat_cnt increments on each W handshake.
  - Handshake with wlast = 1: go to B.
- **B**
  - bready = 1.
  - On bvalid: err |= (bresp != OKAY); go to DONE.
- **AR**
  - Same as AW but on the read address channel; go to R on arready.
- **R**
  - rd_valid = rvalid, rd_data = rdata, rd_last = rlast, rready = rd_ready.
  - On each handshake: beat_cnt++ and err |= (rresp != OKAY).
  - If rlast arrives with beat_cnt != len (early termination, as on the slave's SLVERR path): err = 1.
  - Handshake with rlast: go to DONE. Any beat after rlast is not possible because rready = 0 outside R.
- **DONE**
  - done = 1 and done_err = err for exactly one cycle; return to IDLE.
- Outside W, wr_ready = 0. Outside R, rd_valid = 0 and rready = 0.
- cmd_len > MAX_LEN is treated as MAX_LEN. This value is what goes on awlen/arlen.
- beat_cnt is AXI_ALEN_WIDTH+1 bits wide, so 256 beats cannot wrap.

## Timing
- **Reset:** state IDLE, cmd_ready = 1, and all other outputs (every valid/ready, done, done_err, addresses, lengths, wlast, rd_last) = 0.
- **Reset mid-burst:** immediate return to IDLE with no completion pulse.
- **Address latency:** awvalid/arvalid first rise 1 cycle after command accept.
- **Minimum transaction time**, with the slave always ready:
  - Write: 1 (AW) + L+1 (W) + 1 (B) + 1 (DONE) cycles.
  - Read: 1 (AR) + L+1 (R) + 1 (DONE) cycles.
- **Next command:** cmd_ready returns 1 in the cycle after the DONE cycle. There is no overlap between transactions.
- **Valid stability:** a valid, once asserted, is not dropped before its handshake (AXI rule). W and R stall cycles are passed straight through.
- **B arriving early:** bvalid before the final W handshake is ignored, since bready = 0 in W.

## Test plan
- **Single write:** write, addr 0x1000, len 0, data 0xDEADBEEF; slave always ready → one AW beat (awlen 0), one W beat with wlast, then done = 1 with done_err = 0. Total 4 cycles from accept to done.
- **Burst write with backpressure:** write, len 3; wready toggles every other cycle → 4 W beats in order, wlast only on beat 4, no dropped or duplicated data.
- **Burst read with stalls:** read, addr 0x2000, len 7, with rd_ready randomized → 8 beats delivered, rd_last on the 8th, done_err = 0.
- **Read error:** read from an unmapped address; slave returns a single SLVERR beat with rlast → done pulse with done_err = 1; engine back in IDLE.
- **Write error:** slave returns bresp = SLVERR → done_err = 1; the next command is accepted normally.
- **Reset during W:** assert arst_axi at beat 2 of a len-5 write → all outputs 0 the same cycle, no done pulse, cmd_ready = 1 after release.
